ddr_deserialiser: RTL and testbench
===================================

# ddr_deserialiser

Receive-side DDR deserialiser for the read data path. It samples the DQ lanes on both clock edges during a capture window of BL/2 cycles and assembles one burst of BL beats per lane into a parallel word. When the burst completes it presents the word with a single-cycle valid strobe. It is the counterpart of the write-path serialiser and feeds the read-data return logic of the controller.

## Interface
Parameters:
- BL, default 16: burst length in beats; even, 2..16.
- LANES, default 1: number of DQ lanes captured in parallel.

Ports:
- clk_i  in  1  DDR clock; beats are sampled on both edges.
- rst_n  in  1  reset, synchronous, active-low; clock clk_i.
- dq_i  in  LANES  serial data from the pads.
- cap_en_i  in  1  capture window; high for exactly BL/2 consecutive cycles per burst.
- data_o  out  LANES*BL  assembled burst; lane l, beat b at bit b*LANES+l.
- valid_o  out  1  one-cycle pulse: data_o updated with a complete burst.
- err_o  out  1  one-cycle pulse: burst truncated and discarded.
- busy_o  out  1  high while in CAPTURE.

## Operation
- Falling-edge register neg_q samples dq_i on every negedge of clk_i.
  - It resets to 0 on a negedge where rst_n=0.
  - All other state is posedge-only.
- Beat mapping:
  - Rising edge k of the window carries beat 2k.
  - The following falling edge carries beat 2k+1.
- State machine, two states: IDLE and CAPTURE.
- cnt (width clog2(BL/2)+1) counts rising edges consumed.
- IDLE, rising edge with cap_en_i=1:
  - asm[beat 0] <= dq_i.
  - cnt <= 1.
  - Go to CAPTURE.
- CAPTURE, cnt < BL/2, cap_en_i=1:
  - asm[beat 2cnt] <= dq_i.
  - asm[beat 2cnt-1] <= neg_q.
  - cnt++.
- CAPTURE, cnt < BL/2, cap_en_i=0 (truncation):
  - err_o=1 for one cycle; go to IDLE.
  - data_o unchanged; no valid_o.
  - The assembly buffer is not cleared.
- CAPTURE, cnt == BL/2 (completion edge):
  - data_o <= asm with beat BL-1 = neg_q; valid_o=1.
  - If cap_en_i=1 (back-to-back burst): asm[beat 0] <= dq_i, cnt <= 1, stay in CAPTURE, no gap cycle.
  - Else go to IDLE.
- The assembly buffer asm is separate from data_o. data_o holds the last complete burst until the next completion edge.
- busy_o = (state == CAPTURE).

## Timing
- Reset values:
  - data_o = 0, valid_o = 0, err_o = 0, busy_o = 0.
  - state IDLE, cnt 0, asm 0, neg_q 0.
- Latency: valid_o rises at the first rising edge after the last cap_en_i-high cycle, i.e. BL/2 rising edges after the first capture edge.
- valid_o and err_o are registered single-cycle pulses and are never high together.
- cap_en_i high for more than BL/2 cycles is treated as a back-to-back burst. An incomplete trailing burst then raises err_o when cap_en_i drops.
- BL=2: the completion edge is the rising edge immediately after the start edge.
- Reset asserted mid-burst: abort at that edge, return to IDLE, clear outputs, no valid_o and no err_o.
- dq_i must be stable around both clock edges. No internal delay or deskew; alignment is the upstream training logic's job.

## Test plan
- Basic burst (BL=16, LANES=1): drive burst 0xA5C3 with beat b = bit b, cap_en_i high 8 cycles.
  - Expect data_o=0xA5C3 and valid_o for 1 cycle, exactly 8 rising edges after the start edge.
  - Expect err_o=0.
- Back-to-back (BL=16): drive 0x1234 then 0xFEDC with cap_en_i high for 16 cycles.
  - Expect two valid_o pulses 8 cycles apart, carrying 0x1234 then 0xFEDC.
  - Expect busy_o continuously high between them.
- Truncation (BL=16): drop cap_en_i after 5 cycles.
  - Expect err_o one pulse at the next edge, no valid_o, data_o retains the prior burst, state returns to IDLE.
- Reset mid-burst: assert rst_n=0 at cycle 3 of a window.
  - Expect data_o=0, valid_o=0, err_o=0, busy_o=0.
  - A following clean burst 0x00FF is captured correctly.
- Multi-lane, minimum BL (BL=2, LANES=4): beat0=0x9, beat1=0x6.
  - Expect data_o=0x69 and valid_o one cycle after the single-cycle window.
- Idle stability: toggle dq_i randomly with cap_en_i=0 for 50 cycles.
  - Expect data_o unchanged and no valid_o or err_o pulses.

Source files
------------

// File: rtl/ddr_deserialiser_if.sv
// Bundle of the pad-side serial inputs and the parallel burst outputs of the
// read-path DDR deserialiser. The master side drives DQ and the capture
// window; the slave side (the deserialiser) returns the assembled burst.
interface ddr_deserialiser_if #(
    parameter int BL    = 16,
    parameter int LANES = 1
);
    logic [LANES-1:0]    dq_i;
    logic                cap_en_i;
    logic [LANES*BL-1:0] data_o;
    logic                valid_o;
    logic                err_o;
    logic                busy_o;

    modport master (
        output dq_i, cap_en_i,
        input  data_o, valid_o, err_o, busy_o
    );

    modport slave (
        input  dq_i, cap_en_i,
        output data_o, valid_o, err_o, busy_o
    );
endinterface

// File: rtl/ddr_deserialiser.sv
// Receive-side DDR deserialiser. Beats are sampled on both edges of clk_i
// during a capture window of BL/2 cycles and assembled into one parallel
// word per burst (lane l, beat b at bit b*LANES+l). A complete burst is
// published with a one-cycle valid pulse; a window that drops early raises
// a one-cycle error pulse and leaves the published word untouched.
module ddr_deserialiser #(
    parameter int BL    = 16,
    parameter int LANES = 1
) (
    input  logic              clk_i,
    input  logic              rst_n,
    ddr_deserialiser_if.slave bus
);
    localparam int HALF = BL / 2;
    localparam int CW   = $clog2(HALF) + 1;
    localparam int W    = LANES * BL;
    localparam logic [CW-1:0] HALF_C = CW'(HALF);

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [W-1:0]     asm_reg;
    logic [W-1:0]     data_reg;
    logic             valid_reg;
    logic             err_reg;
    logic [LANES-1:0] neg_q;

    logic [W-1:0]     asm_done;
    int               even_base;
    int               odd_base;

    // Falling-edge sample; holds the odd beat until the next rising edge
    // writes it into the assembly buffer.
    always_ff @(negedge clk_i) begin
        if (!rst_n) begin
            neg_q <= '0;
        end else begin
            neg_q <= bus.dq_i;
        end
    end

    // Completed word (last beat still lives in neg_q) and the bit offsets
    // of the beat pair consumed at the current rising edge.
    always_comb begin
        asm_done                              = asm_reg;
        asm_done[(BL-1)*LANES +: LANES]       = neg_q;
        even_base                             = 2 * int'(cnt_reg) * LANES;
        odd_base                              = (2 * int'(cnt_reg) - 1) * LANES;
    end

    // Capture state machine with registered valid/err pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            asm_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cap_en_i) begin
                        asm_reg[0 +: LANES] <= bus.dq_i;
                        cnt_reg             <= CW'(1);
                        state_reg           <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cnt_reg == HALF_C) begin
                        // Completion edge: publish, and restart immediately
                        // if the window is still open (back-to-back burst).
                        data_reg  <= asm_done;
                        valid_reg <= 1'b1;
                        if (bus.cap_en_i) begin
                            asm_reg[0 +: LANES] <= bus.dq_i;
                            cnt_reg             <= CW'(1);
                        end else begin
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end
                    end else if (bus.cap_en_i) begin
                        asm_reg[even_base +: LANES] <= bus.dq_i;
                        asm_reg[odd_base +: LANES]  <= neg_q;
                        cnt_reg                     <= cnt_reg + 1'b1;
                    end else begin
                        // Window closed early: drop the partial burst.
                        err_reg   <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_o  = data_reg;
    assign bus.valid_o = valid_reg;
    assign bus.err_o   = err_reg;
    assign bus.busy_o  = (state_reg == CAPTURE);
endmodule

// File: tb/tb_ddr_deserialiser.sv
// Bench for the DDR deserialiser: one BL=16/LANES=1 instance and one
// BL=2/LANES=4 instance share clock and reset. Stimulus pushes expected
// bursts/errors (with the cycle they are due) into a queue; a negedge
// monitor pops and compares whenever an instance pulses valid or err.
module tb_ddr_deserialiser;
    logic clk;
    logic rst_n;

    ddr_deserialiser_if #(.BL(16), .LANES(1)) bus16 ();
    ddr_deserialiser_if #(.BL(2),  .LANES(4)) bus2 ();

    ddr_deserialiser #(.BL(16), .LANES(1)) u_dut16 (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    ddr_deserialiser #(.BL(2), .LANES(4)) u_dut2 (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        int         sel;
        bit         is_err;
        int         cyc;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [63:0] model_data [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to time-stamp expected events.
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_out(input int sel, input logic v, input logic e, input logic [63:0] d);
        int   idx;
        exp_t x;
        if (!rst_n) model_data[sel] = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].sel == sel && exp_q[i].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_event dut%0d: actual none, required %s due cycle %0d (now %0d)",
                         sel, exp_q[i].is_err ? "err" : "valid", exp_q[i].cyc, cyc);
                exp_q.delete(i);
            end
        end
        tests++;
        if (v === 1'b1 && e === 1'b1) begin
            fails++;
            $display("FAIL both_pulses dut%0d: actual valid=1 err=1, required at most one (cycle %0d)", sel, cyc);
        end
        if (v === 1'b1 || e === 1'b1) begin
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (idx < 0 && exp_q[i].sel == sel) idx = i;
            end
            tests++;
            if (idx < 0) begin
                fails++;
                $display("FAIL unexpected_event dut%0d: actual valid=%0b err=%0b data=0x%0h, required none (cycle %0d)",
                         sel, v, e, d, cyc);
            end else begin
                x = exp_q[idx];
                exp_q.delete(idx);
                if (x.is_err != e || x.cyc != cyc || (v === 1'b1 && d !== x.data)) begin
                    fails++;
                    $display("FAIL event dut%0d: actual err=%0b cyc=%0d data=0x%0h, required err=%0b cyc=%0d data=0x%0h",
                             sel, e, cyc, d, x.is_err, x.cyc, x.data);
                end else begin
                    $display("[TB] dut%0d %s at cycle %0d data=0x%0h", sel, e ? "err" : "valid", cyc, d);
                end
                if (v === 1'b1) model_data[sel] = x.data;
            end
        end
        if (v !== 1'b1) begin
            tests++;
            if (d !== model_data[sel]) begin
                fails++;
                $display("FAIL data_hold dut%0d: actual 0x%0h required 0x%0h (cycle %0d)",
                         sel, d, model_data[sel], cyc);
            end
        end
    endtask

    // Output monitor, sampled on the edge opposite to the DUT update edge.
    always @(negedge clk) begin
        check_out(0, bus16.valid_o, bus16.err_o, 64'(bus16.data_o));
        check_out(1, bus2.valid_o,  bus2.err_o,  64'(bus2.data_o));
    end

    // One clock cycle: even beat before the rising edge, odd beat before the
    // falling edge. The unselected instance idles with random DQ.
    task automatic drive_cycle(input int sel, input bit cap, input logic [3:0] ev, input logic [3:0] od);
        logic c16;
        logic c2;
        c16 = (sel == 0) && cap;
        c2  = (sel == 1) && cap;
        bus16.cap_en_i = c16;
        bus2.cap_en_i  = c2;
        bus16.dq_i     = (sel == 0) ? ev[0] : 1'($urandom);
        bus2.dq_i      = (sel == 1) ? ev : 4'($urandom);
        @(posedge clk);
        #2;
        bus16.dq_i = (sel == 0) ? od[0] : 1'($urandom);
        bus2.dq_i  = (sel == 1) ? od : 4'($urandom);
        chk("busy16", 64'(bus16.busy_o), 64'(c16 && rst_n));
        chk("busy2",  64'(bus2.busy_o),  64'(c2 && rst_n));
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive_cycle(0, 1'b0, 4'($urandom), 4'($urandom));
    endtask

    // Opens a window of n cycles on instance sel. The first nw bursts carry
    // w0/w1, the rest random beats. The window splits into n/(BL/2) complete
    // bursts, plus one truncation error if a remainder is left over.
    task automatic run_window(input int sel, input int n, input logic [63:0] w0,
                              input logic [63:0] w1, input int nw);
        int          L;
        int          bl;
        int          half;
        int          s;
        logic [3:0]  mask;
        logic [3:0]  b4;
        logic [63:0] w;
        logic [3:0]  beats[$];
        exp_t        x;
        L    = (sel != 0) ? 4 : 1;
        bl   = (sel != 0) ? 2 : 16;
        half = bl / 2;
        mask = 4'((1 << L) - 1);
        for (int b = 0; b < 2 * n; b++) begin
            b4 = 4'($urandom) & mask;
            if (b / bl < nw) begin
                w  = (b / bl == 0) ? w0 : w1;
                b4 = 4'(w >> ((b % bl) * L)) & mask;
            end
            beats.push_back(b4);
        end
        s = cyc + 1;
        for (int i = 0; i < n / half; i++) begin
            w = '0;
            for (int b = 0; b < bl; b++) w = w | (64'(beats[i * bl + b]) << (b * L));
            x = '{sel, 1'b0, s + half * (i + 1), w};
            exp_q.push_back(x);
        end
        if (n % half != 0) begin
            x = '{sel, 1'b1, s + n, 64'd0};
            exp_q.push_back(x);
        end
        for (int k = 0; k < n; k++) drive_cycle(sel, 1'b1, beats[2 * k], beats[2 * k + 1]);
        idle(2);
    endtask

    initial begin
        model_data[0] = '0;
        model_data[1] = '0;
        rst_n          = 1'b0;
        bus16.cap_en_i = 1'b0;
        bus2.cap_en_i  = 1'b0;
        bus16.dq_i     = '0;
        bus2.dq_i      = '0;
        @(negedge clk);
        #2;
        idle(3);

        // Reset state
        chk("rst_data16",  64'(bus16.data_o),  64'd0);
        chk("rst_valid16", 64'(bus16.valid_o), 64'd0);
        chk("rst_err16",   64'(bus16.err_o),   64'd0);
        chk("rst_busy16",  64'(bus16.busy_o),  64'd0);
        chk("rst_data2",   64'(bus2.data_o),   64'd0);
        chk("rst_valid2",  64'(bus2.valid_o),  64'd0);
        chk("rst_err2",    64'(bus2.err_o),    64'd0);
        chk("rst_busy2",   64'(bus2.busy_o),   64'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic burst, back-to-back pair, truncation
        run_window(0, 8, 64'hA5C3, 64'h0, 1);
        run_window(0, 16, 64'h1234, 64'hFEDC, 2);
        run_window(0, 5, 64'h0, 64'h0, 0);
        idle(2);

        // Reset asserted at cycle 3 of a window, then a clean burst
        for (int k = 0; k < 3; k++) drive_cycle(0, 1'b1, 4'($urandom), 4'($urandom));
        rst_n = 1'b0;
        drive_cycle(0, 1'b1, 4'($urandom), 4'($urandom));
        chk("midrst_data16",  64'(bus16.data_o),  64'd0);
        chk("midrst_valid16", 64'(bus16.valid_o), 64'd0);
        chk("midrst_err16",   64'(bus16.err_o),   64'd0);
        chk("midrst_busy16",  64'(bus16.busy_o),  64'd0);
        rst_n = 1'b1;
        idle(2);
        run_window(0, 8, 64'h00FF, 64'h0, 1);

        // Random windows, including multi-burst and truncated tails
        for (int i = 0; i < 8; i++) begin
            run_window(0, int'($urandom_range(1, 20)), 64'h0, 64'h0, 0);
            idle(int'($urandom_range(0, 3)));
        end

        // Minimum burst length, four lanes
        run_window(1, 1, 64'h69, 64'h0, 1);
        for (int i = 0; i < 6; i++) begin
            run_window(1, int'($urandom_range(1, 4)), 64'h0, 64'h0, 0);
            idle(int'($urandom_range(0, 2)));
        end

        // Idle stability with toggling DQ
        idle(50);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_events: actual %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
